// File: rtl/cache_nway_pkg.sv
// Shared types and widths for the N-way set-associative cache.
package cache_types_pkg;

    localparam int ADDR_W   = 16;
    localparam int WORD_W   = 16;
    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } cache_state_t;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets);
        return ADDR_W - OFFSET_W - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// Tree pseudo-LRU: victim selection and next-state update for one set.
// Node n has children 2n+1 (left) and 2n+2 (right); a node bit of 1 sends
// the victim search to the right subtree.
module plru_tree #(
    parameter int WAYS = 4,
    localparam int PB = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PB-1:0] bits,
    input  logic [WW-1:0] touch_way,
    output logic [WW-1:0] victim,
    output logic [PB-1:0] bits_next
);

    localparam int LVL = (WAYS > 1) ? $clog2(WAYS) : 0;

    // Follow the node bits from the root down to the victim leaf.
    always_comb begin
        int node;
        logic [PB-1:0] sh;
        node = 0;
        sh   = bits;
        for (int l = 0; l < LVL; l++) begin
            sh   = bits >> node;
            node = 2 * node + 1 + int'(sh[0]);
        end
        victim = WW'(node - (WAYS - 1));
    end

    // Along the touched way's path, point each node at the other subtree.
    always_comb begin
        int node;
        logic [WW-1:0] tsh;
        logic [PB-1:0] mask;
        node      = 0;
        tsh       = touch_way;
        mask      = '0;
        bits_next = bits;
        for (int l = 0; l < LVL; l++) begin
            tsh  = touch_way >> (LVL - 1 - l);
            mask = PB'(1) << node;
            if (tsh[0]) begin
                bits_next = bits_next & ~mask;
            end else begin
                bits_next = bits_next | mask;
            end
            node = 2 * node + 1 + int'(tsh[0]);
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back / write-allocate cache with tree PLRU.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined;
// otherwise both counter ports are tied to zero.
module cache_nway
    import cache_types_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_byte_enable,
    input  logic [WORD_W-1:0]  mem_wdata,
    output logic [WORD_W-1:0]  mem_rdata,
    output logic               mem_resp,
    output logic [ADDR_W-1:0]  pmem_address,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [LINE_W-1:0]  pmem_wdata,
    input  logic [LINE_W-1:0]  pmem_rdata,
    input  logic               pmem_resp,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
);

    localparam int IDX_W = index_w(SETS);
    localparam int TAG_W = tag_w(SETS);
    localparam int PB    = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic              valid_q [WAYS][SETS];
    logic              dirty_q [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [PB-1:0]     plru_q  [SETS];

    cache_state_t      state_q;
    logic [WW-1:0]     victim_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [TAG_W-1:0]  req_tag_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        word_sel;
    logic              unused_addr_bit;

    assign idx             = mem_address[OFFSET_W +: IDX_W];
    assign tag             = mem_address[ADDR_W-1 -: TAG_W];
    assign word_sel        = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    logic              req;
    logic              hit_any;
    logic [WW-1:0]     hit_way;
    logic              inv_any;
    logic [WW-1:0]     inv_way;
    logic              hit;
    logic              miss_start;
    logic [WW-1:0]     tree_victim;
    logic [WW-1:0]     miss_victim;
    logic [PB-1:0]     plru_next;
    logic [LINE_W-1:0] hit_line;

    // Tag compare across ways; lowest-index hit and lowest-index invalid way win.
    always_comb begin
        req     = mem_read | mem_write;
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[w][idx]) begin
                inv_any = 1'b1;
                inv_way = WW'(w);
            end
        end
        hit         = (state_q == ST_IDLE) && req && hit_any;
        miss_start  = (state_q == ST_IDLE) && req && !hit_any;
        miss_victim = inv_any ? inv_way : tree_victim;
        hit_line    = data_q[hit_way][idx];
        mem_resp    = hit;
        mem_rdata   = (hit && !mem_write) ? hit_line[{word_sel, 4'b0000} +: WORD_W] : '0;
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits      (plru_q[idx]),
        .touch_way (hit_way),
        .victim    (tree_victim),
        .bits_next (plru_next)
    );

    // Control FSM; memory-side strobes, address and victim data are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            victim_q     <= '0;
            req_idx_q    <= '0;
            req_tag_q    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_start) begin
                        victim_q  <= miss_victim;
                        req_idx_q <= idx;
                        req_tag_q <= tag;
                        if (!inv_any && dirty_q[miss_victim][idx]) begin
                            state_q      <= ST_WRITEBACK;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_q[miss_victim][idx], idx, 4'b0000};
                            pmem_wdata   <= data_q[miss_victim][idx];
                        end else begin
                            state_q      <= ST_FILL;
                            pmem_read    <= 1'b1;
                            pmem_address <= {tag, idx, 4'b0000};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem_resp) begin
                        state_q      <= ST_FILL;
                        pmem_write   <= 1'b0;
                        pmem_wdata   <= '0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag_q, req_idx_q, 4'b0000};
                    end
                end
                ST_FILL: begin
                    if (pmem_resp) begin
                        state_q      <= ST_IDLE;
                        pmem_read    <= 1'b0;
                        pmem_address <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    pmem_read    <= 1'b0;
                    pmem_write   <= 1'b0;
                    pmem_address <= '0;
                    pmem_wdata   <= '0;
                end
            endcase
        end
    end

    // Array updates: write-hit byte merge plus PLRU touch, and line fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    tag_q[w][s]   <= '0;
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    data_q[w][s]  <= '0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            if (hit) begin
                plru_q[idx] <= plru_next;
                if (mem_write) begin
                    if (mem_byte_enable[0]) begin
                        data_q[hit_way][idx][{word_sel, 4'b0000} +: 8] <= mem_wdata[7:0];
                    end
                    if (mem_byte_enable[1]) begin
                        data_q[hit_way][idx][{word_sel, 4'b1000} +: 8] <= mem_wdata[15:8];
                    end
                    dirty_q[hit_way][idx] <= 1'b1;
                end
            end
            if ((state_q == ST_FILL) && pmem_resp) begin
                data_q[victim_q][req_idx_q]  <= pmem_rdata;
                tag_q[victim_q][req_idx_q]   <= req_tag_q;
                valid_q[victim_q][req_idx_q] <= 1'b1;
                dirty_q[victim_q][req_idx_q] <= 1'b0;
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // Saturating hit / miss counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-back, write-allocate cache with pseudo-LRU replacement. It sits between the LC-3b CPU memory port and physical memory. It combines the tag/valid/dirty/data arrays, hit logic and control FSM in one block. It generalises the fixed 2-way cache to configurable associativity and set count, and adds optional performance counters.

## Interface
- `WAYS`, 4, associativity; legal values 1, 2, 4, 8.
- `SETS`, 8, sets per way; power of two, ≥ 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `mem_address` input 16: CPU byte address.
- `mem_read` input 1: CPU read request, held until `mem_resp`.
- `mem_write` input 1: CPU write request, held until `mem_resp`.
- `mem_byte_enable` input 2: byte lanes of the write word.
- `mem_wdata` input 16: write word.
- `mem_rdata` output 16: read word, valid while `mem_resp`.
- `mem_resp` output 1: one-cycle completion pulse.
- `pmem_address` output 16: line-aligned address; low 4 bits are 0.
- `pmem_read` output 1: line fill request.
- `pmem_write` output 1: line writeback request.
- `pmem_wdata` output 128: victim line.
- `pmem_rdata` input 128: fill line.
- `pmem_resp` input 1: physical memory done; one-cycle pulse.
- `hit_count` output 16: hit counter.
- `miss_count` output 16: miss counter.

## Operation
- Address split: offset [3:0] (word = [3:1]), index [3+log2(SETS):4], tag = remaining upper bits.
- Arrays are flop-based, read combinationally; all arrays reset to 0.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, no request: all outputs 0.
- IDLE, request hits (valid & tag match in any way):
  - `mem_resp`=1 combinationally.
  - Read: `mem_rdata` = selected word.
  - Write: merge `mem_wdata` per byte enable and set dirty at the edge.
  - PLRU for the set updated toward the hit way.
- IDLE, miss: pick victim = lowest-index invalid way, else PLRU way.
  - Victim valid & dirty: go to WRITEBACK.
  - Otherwise: go to FILL.
- WRITEBACK:
  - `pmem_write`=1, `pmem_address`={victim tag, index, 4'b0}, `pmem_wdata`=victim line.
  - On `pmem_resp`, go to FILL.
- FILL:
  - `pmem_read`=1, `pmem_address`={req tag, index, 4'b0}.
  - On `pmem_resp`, write line, tag, valid=1, dirty=0 into the victim way; go to IDLE.
  - The request is then re-checked and hits.
- PLRU: tree of WAYS−1 bits per set; each node points away from the last-used subtree. WAYS=1 has no PLRU state.
- `mem_read` and `mem_write` both high: treated as a write.
- Victim way is latched on leaving IDLE; it is stable through WRITEBACK/FILL.

## Timing
- Reset: state IDLE; all valid/dirty/PLRU bits 0; all outputs 0, counters 0.
- Reset asserted mid-WRITEBACK/FILL: `pmem_*` strobes drop immediately; the transaction is abandoned; no array is written.
- Hit latency: 0 cycles (response in the request cycle).
- Clean miss: fill cycles + 1.
- Dirty miss: writeback cycles + fill cycles + 1.
- `pmem_read`/`pmem_write` are held level until `pmem_resp`; never both high.
- The CPU must drop or change its request in the cycle after `mem_resp`. A held request is served again.

## Configuration
- `CACHE_PERF_CNT_EN` defined:
  - `hit_count` increments on each hit `mem_resp`.
  - `miss_count` increments on each IDLE→WRITEBACK/FILL transition.
  - Both saturate at 16'hFFFF.
- `CACHE_PERF_CNT_EN` undefined: counters are not built; both ports are tied to 0.

## Structure
- Package `cache_types_pkg`: ADDR_W=16, WORD_W=16, LINE_W=128, OFFSET_W=4, state enum `cache_state_t`, index/tag width functions.
- Sub-module `plru_tree`: combinational victim select plus next-state bits, parametrised by WAYS; one instance shared across sets, fed with the indexed set's bits.

## Test plan
WAYS=4, SETS=8.
- Reset, read 0x0042:
  - `pmem_read` at 0x0040; return line with word1=0x1234.
  - `mem_resp` with 0x1234 one cycle after `pmem_resp`.
  - Reread 0x0042: `mem_resp` same cycle, `miss_count`=1, `hit_count`=2.
- Read 0x0000, 0x0080, 0x0100, 0x0180, then 0x0200:
  - Five fills.
  - 5th replaces way 0: reread 0x0000 misses; 0x0080 hits.
- Write 0xBEEF, be=11, to 0x0002, then force its eviction:
  - `pmem_write` at 0x0000 with `pmem_wdata`[31:16]=0xBEEF, before the fill `pmem_read`.
- Line holding 0xAAAA at 0x0004; write 0x0012, be=01:
  - Read 0x0004 returns 0xAA12.
- Assert `rst` during FILL:
  - `pmem_read` drops same cycle.
  - Subsequent read of the same address misses again.
- Build without `CACHE_PERF_CNT_EN`:
  - Counters stay 0 through all scenarios above.
